ctrl_reg_bank: RTL and testbench

Parametrised control/status register bank giving a bus master read/write access to per-channel control words, an event status register with write-1-to-clear semantics, and a maskable interrupt. It sits between the master's simple address/strobe bus and the datapath channels, whose control inputs it drives. Reads are registered with a valid strobe, and accesses to unmapped addresses are flagged.

---
 rtl/ctrl_reg_bank.sv | 152 +++++++++++++++
 tb/tb_ctrl_reg_bank.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_reg_bank.sv
// ---------------------------------------------------------------------------
// ctrl_reg_bank
//
// Control/status register bank that sits between a bus master's simple
// address/strobe bus and a set of datapath channels. It holds one control
// word per channel, an interrupt mask, and an event status register with
// write-1-to-clear semantics. It also produces a registered, maskable
// interrupt.
//
// Word-indexed address map:
//   0       ID          read-only identification word (writes ignored)
//   1       LOCK        only with CTRL_REG_BANK_LOCK_EN, otherwise unmapped
//   2       IRQ_MASK    bits [NUM_CH-1:0]
//   3       IRQ_STATUS  set by event_in, write 1 to clear
//   16+n    CH_CTRL[n]  bits [CH_W-1:0], n < NUM_CH
//   Any other index is unmapped: reads return 0 and any access pulses
//   access_error.
//
// Optional feature macro: CTRL_REG_BANK_LOCK_EN
//   When defined, bit 0 at index 1 is a sticky lock that only reset clears.
//   While the lock is set, writes to IRQ_MASK and CH_CTRL are discarded and
//   flagged on access_error. IRQ_STATUS clears are still accepted.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous, active-low reset
//   address       word index of the current access
//   write_enable  write strobe
//   write_data    write payload
//   read_enable   read strobe
//   read_data     registered read result; holds its value between reads
//   read_valid    one-cycle pulse that qualifies read_data
//   access_error  one-cycle pulse for an unmapped or locked access
//   event_in      per-channel event pulses
//   ch_ctrl       channel n control word at bits [n*CH_W +: CH_W]
//   irq           registered OR of (IRQ_STATUS & IRQ_MASK)
// ---------------------------------------------------------------------------
module ctrl_reg_bank #(
  parameter int          ADDR_W   = 8,
  parameter int          DATA_W   = 32,
  parameter int          NUM_CH   = 4,
  parameter int          CH_W     = 16,
  parameter logic [31:0] ID_VALUE = 32'h0002_0001
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      address,
  input  logic                   write_enable,
  input  logic [DATA_W-1:0]      write_data,
  input  logic                   read_enable,
  output logic [DATA_W-1:0]      read_data,
  output logic                   read_valid,
  output logic                   access_error,
  input  logic [NUM_CH-1:0]      event_in,
  output logic [NUM_CH*CH_W-1:0] ch_ctrl,
  output logic                   irq
);

  localparam int CH_BASE = 16;

  logic [NUM_CH-1:0]      mask_q;
  logic [NUM_CH-1:0]      status_q;
  logic [NUM_CH*CH_W-1:0] ch_q;
  logic                   lock_q;

  logic                   is_id;
  logic                   is_lock;
  logic                   is_mask;
  logic                   is_status;
  logic [NUM_CH-1:0]      ch_hit;
  logic                   mapped;
  logic                   protected_hit;
  logic                   write_ok;
  logic [NUM_CH-1:0]      clear_bits;
  logic [DATA_W-1:0]      rd_value;

  // Every write_data bit feeds this reduction, so partial use of the bus
  // under narrow parameterisations does not read as a dangling input.
  logic                   unused_write_bits;
  assign unused_write_bits = ^write_data;

`ifndef CTRL_REG_BANK_LOCK_EN
  assign lock_q = 1'b0;
`endif

  // Address decode and read mux. The read value comes from the current
  // register contents, so a read issued together with a write returns the
  // value that was there before the write.
  always_comb begin
    is_id     = (address == ADDR_W'(0));
`ifdef CTRL_REG_BANK_LOCK_EN
    is_lock   = (address == ADDR_W'(1));
`else
    is_lock   = 1'b0;
`endif
    is_mask   = (address == ADDR_W'(2));
    is_status = (address == ADDR_W'(3));
    ch_hit    = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      ch_hit[n] = (address == ADDR_W'(CH_BASE + n));
    end
    mapped        = is_id | is_lock | is_mask | is_status | (|ch_hit);
    protected_hit = is_mask | (|ch_hit);
    write_ok      = write_enable & ~(lock_q & protected_hit);
    clear_bits    = (write_enable & is_status) ? write_data[NUM_CH-1:0] : '0;

    rd_value = '0;
    if (is_id)     rd_value = ID_VALUE[DATA_W-1:0];
    if (is_lock)   rd_value[0] = lock_q;
    if (is_mask)   rd_value[NUM_CH-1:0] = mask_q;
    if (is_status) rd_value[NUM_CH-1:0] = status_q;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_hit[n]) rd_value[CH_W-1:0] = ch_q[n*CH_W +: CH_W];
    end
  end

  // Register state and registered outputs. In IRQ_STATUS, a new event is
  // ORed in after the W1C clear, so a set in the same cycle wins. irq is
  // built from the pre-edge status and mask, which puts two edges between
  // an event and the irq change.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_data    <= '0;
      read_valid   <= 1'b0;
      access_error <= 1'b0;
      irq          <= 1'b0;
      mask_q       <= '0;
      status_q     <= '0;
      ch_q         <= '0;
`ifdef CTRL_REG_BANK_LOCK_EN
      lock_q       <= 1'b0;
`endif
    end else begin
      read_valid <= read_enable;
      if (read_enable) read_data <= rd_value;
      access_error <= ((read_enable | write_enable) & ~mapped)
                    | (write_enable & lock_q & protected_hit);
      if (write_ok & is_mask) mask_q <= write_data[NUM_CH-1:0];
      status_q <= (status_q & ~clear_bits) | event_in;
      for (int n = 0; n < NUM_CH; n++) begin
        if (write_ok & ch_hit[n]) ch_q[n*CH_W +: CH_W] <= write_data[CH_W-1:0];
      end
      irq <= |(status_q & mask_q);
`ifdef CTRL_REG_BANK_LOCK_EN
      if (write_enable & is_lock & write_data[0]) lock_q <= 1'b1;
`endif
    end
  end

  assign ch_ctrl = ch_q;

endmodule

// File: tb/tb_ctrl_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_ctrl_reg_bank
//
// Self-checking bench for ctrl_reg_bank with default parameters. A
// behavioural register-map model predicts every output after each clock.
// The bench runs directed steps and then randomized bus traffic.
// Lock-specific steps are compiled in only with CTRL_REG_BANK_LOCK_EN.
// ---------------------------------------------------------------------------
module tb_ctrl_reg_bank;

  localparam int          ADDR_W   = 8;
  localparam int          DATA_W   = 32;
  localparam int          NUM_CH   = 4;
  localparam int          CH_W     = 16;
  localparam logic [31:0] ID_VALUE = 32'h0002_0001;
  localparam logic [31:0] ST_BITS  = (32'd1 << NUM_CH) - 32'd1;
  localparam logic [31:0] CH_BITS  = (32'd1 << CH_W) - 32'd1;
`ifdef CTRL_REG_BANK_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic [ADDR_W-1:0]      address = '0;
  logic                   write_enable = 1'b0;
  logic [DATA_W-1:0]      write_data = '0;
  logic                   read_enable = 1'b0;
  logic [DATA_W-1:0]      read_data;
  logic                   read_valid;
  logic                   access_error;
  logic [NUM_CH-1:0]      event_in = '0;
  logic [NUM_CH*CH_W-1:0] ch_ctrl;
  logic                   irq;

  ctrl_reg_bank #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .ID_VALUE(ID_VALUE)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .write_enable(write_enable),
    .write_data(write_data), .read_enable(read_enable), .read_data(read_data),
    .read_valid(read_valid), .access_error(access_error), .event_in(event_in),
    .ch_ctrl(ch_ctrl), .irq(irq)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int step   = 0;

  // Reference model state: the register map seen as plain words.
  logic [31:0] m_mask;
  logic [31:0] m_status;
  logic [31:0] m_ch [NUM_CH];
  bit          m_lock;
  logic [31:0] m_read_data;
  bit          m_valid;
  bit          m_err;
  bit          m_irq;

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s (step %0d): observed %0h expected %0h", tag, step, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_mask = '0; m_status = '0; m_lock = 1'b0; m_read_data = '0;
    m_valid = 1'b0; m_err = 1'b0; m_irq = 1'b0;
    for (int n = 0; n < NUM_CH; n++) m_ch[n] = '0;
  endtask

  function automatic bit is_channel(input int unsigned a);
    return (a >= 16) && (a < 16 + NUM_CH);
  endfunction

  function automatic bit is_mapped(input int unsigned a);
    return (a == 0) || (a == 1 && LOCK_EN) || (a == 2) || (a == 3) || is_channel(a);
  endfunction

  function automatic logic [31:0] model_read(input int unsigned a);
    if (a == 0) return ID_VALUE;
    if (a == 1 && LOCK_EN) return {31'b0, m_lock};
    if (a == 2) return m_mask;
    if (a == 3) return m_status;
    if (is_channel(a)) return m_ch[a - 16];
    return 32'h0;
  endfunction

  function automatic logic [63:0] model_ch_ctrl();
    logic [63:0] v;
    v = '0;
    for (int n = 0; n < NUM_CH; n++) v[n*CH_W +: CH_W] = m_ch[n][CH_W-1:0];
    return v;
  endfunction

  task automatic check_all();
    check_output("read_valid", read_valid, m_valid);
    check_output("read_data", read_data, m_read_data);
    check_output("access_error", access_error, m_err);
    check_output("irq", irq, m_irq);
    check_output("ch_ctrl", ch_ctrl, model_ch_ctrl());
  endtask

  // Drives one bus cycle, advances the model by one clock, and then
  // compares every DUT output against the model.
  task automatic apply_stimulus(input int unsigned addr, input bit we, input logic [31:0] wd,
                                input bit re, input logic [NUM_CH-1:0] ev);
    logic [31:0] old_status;
    logic [31:0] old_mask;
    logic [31:0] clear;
    bit          blocked;
    step++;
    address = addr[ADDR_W-1:0]; write_enable = we; write_data = wd;
    read_enable = re; event_in = ev;
    old_status = m_status; old_mask = m_mask;
    blocked = m_lock && (addr == 2 || is_channel(addr));
    m_valid = re;
    if (re) m_read_data = model_read(addr);
    m_err = ((we || re) && !is_mapped(addr)) || (we && blocked);
    clear = '0;
    if (we && !blocked) begin
      if (addr == 1 && LOCK_EN && wd[0]) m_lock = 1'b1;
      if (addr == 2) m_mask = wd & ST_BITS;
      if (addr == 3) clear = wd;
      if (is_channel(addr)) m_ch[addr - 16] = wd & CH_BITS;
    end
    m_status = ((m_status & ~clear) | {28'b0, ev}) & ST_BITS;
    m_irq = ((old_status & old_mask) != 0);
    @(posedge clock);
    #1;
    check_all();
    write_enable = 1'b0; read_enable = 1'b0; event_in = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, ".read_data"}, read_data, 64'h0);
    check_output({tag, ".read_valid"}, read_valid, 64'h0);
    check_output({tag, ".access_error"}, access_error, 64'h0);
    check_output({tag, ".irq"}, irq, 64'h0);
    check_output({tag, ".ch_ctrl"}, ch_ctrl, 64'h0);
  endtask

  initial begin
    int unsigned a;
    model_reset();
    #1;
    check_reset_state("reset");
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;

    // The ID word reads back with one cycle of latency.
    apply_stimulus(0, 0, 32'h0, 1, '0);
    check_output("id_value", read_data, 64'h0002_0001);

    // Writing a channel keeps only the low CH_W bits.
    apply_stimulus(17, 1, 32'hFFFF_ABCD, 0, '0);
    check_output("ch1_word", ch_ctrl[31:16], 64'hABCD);
    apply_stimulus(17, 0, 32'h0, 1, '0);
    check_output("ch1_readback", read_data, 64'h0000_ABCD);

    // Masked interrupt flow, then a W1C clear.
    apply_stimulus(2, 1, 32'h4, 0, '0);
    apply_stimulus(3, 0, 32'h0, 0, 4'b0110);
    apply_stimulus(3, 0, 32'h0, 1, '0);
    check_output("irq_after_event", irq, 64'h1);
    apply_stimulus(0, 0, 32'h0, 0, '0);
    check_output("status_read", read_data, 64'h6);
    apply_stimulus(3, 1, 32'h4, 0, '0);
    apply_stimulus(3, 0, 32'h0, 1, '0);
    check_output("irq_after_clear", irq, 64'h0);
    apply_stimulus(0, 0, 32'h0, 0, '0);
    check_output("status_after_clear", read_data, 64'h2);

    // An event arriving in the same cycle as the W1C of its bit keeps the bit set.
    apply_stimulus(3, 0, 32'h0, 0, 4'b0100);
    apply_stimulus(3, 1, 32'h4, 0, 4'b0100);
    apply_stimulus(3, 0, 32'h0, 1, '0);
    check_output("set_wins_irq", irq, 64'h1);
    apply_stimulus(0, 0, 32'h0, 0, '0);
    check_output("set_wins_status", read_data[2], 64'h1);

    // Unmapped accesses, and a read issued together with a write.
    apply_stimulus(40, 0, 32'h0, 1, '0);
    check_output("unmapped_read", read_data, 64'h0);
    apply_stimulus(5, 1, 32'hDEAD_BEEF, 0, '0);
    apply_stimulus(0, 0, 32'h0, 0, '0);
    apply_stimulus(1, 1, 32'h0, 1, '0);
    apply_stimulus(18, 1, 32'h0000_5A5A, 1, '0);
    apply_stimulus(18, 0, 32'h0, 1, '0);

`ifdef CTRL_REG_BANK_LOCK_EN
    // Once locked, channel and mask writes are refused. W1C is still accepted.
    apply_stimulus(1, 1, 32'h1, 0, '0);
    apply_stimulus(16, 1, 32'h0000_1234, 0, '0);
    check_output("locked_error", access_error, 64'h1);
    apply_stimulus(1, 1, 32'h0, 1, '0);
    apply_stimulus(2, 1, 32'hF, 0, '0);
    apply_stimulus(3, 1, 32'hF, 1, '0);
`endif

    // Asserting reset mid-sequence clears state immediately, between edges.
    apply_stimulus(19, 1, 32'h0000_7777, 0, 4'b1111);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_reset_state("async_reset");
    @(posedge clock);
    #1;
    check_reset_state("reset_hold");
    #2 reset = 1'b1;
    apply_stimulus(3, 0, 32'h0, 1, '0);
    apply_stimulus(1, 0, 32'h0, 1, '0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 11))
        0: a = 0;  1: a = 1;  2: a = 2;  3: a = 3;
        4: a = 16; 5: a = 17; 6: a = 18; 7: a = 19;
        8: a = 20; 9: a = 5;  10: a = 40; default: a = 255;
      endcase
      apply_stimulus(a, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
